operand_display_scanner: RTL and testbench
==========================================

Name: operand_display_scanner

Overview:
Reads the 13-bit sign-magnitude BCD word {sign, digit3, digit2, digit1} produced by the operand/result registers. Drives it onto a 4-position multiplexed common-anode seven-segment display: three digits plus a sign position. Uses a load/ready handshake with a frame-synchronous shadow register so the display never tears mid-scan. Sits between the operand/result registers and the board display pins.

Parameters:
REFRESH_DIV, 50000, clocks per digit slot; legal range 2 to 2^20.
BLANK_LEADING, 1, 1 = blank leading zeros in digit3/digit2; 0 = always show all digits.

Ports:
Clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
load  input  1  request to display operand; accepted only when ready=1.
operand  input  13  {isNegative, digit3, digit2, digit1}, BCD digits, digit1 = units.
ready  output  1  1 = pending slot empty, load will be accepted.
err  output  1  1 = displayed word contains a non-BCD digit (>9).
an  output  4  anode enables, active-low; an[0]=digit1, an[1]=digit2, an[2]=digit3, an[3]=sign.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (reset=0 at a rising edge):
  - slot counter cnt=0, slot=0, display register=0, pending empty.
  - ready=1, err=0, an=4'b1111, seg=7'b1111111.
  - Reset overrides load and any transfer in progress, including mid-frame.
- Scan:
  - cnt runs 0..REFRESH_DIV-1. At cnt=REFRESH_DIV-1, cnt wraps to 0 and slot advances 0→1→2→3→0.
  - A frame is 4*REFRESH_DIV clocks.
- Outputs: an, seg and err are registered and reflect the slot/cnt state of the previous cycle (1-cycle latency).
- Dead time: while cnt==0, an=4'b1111 and seg=7'b1111111 (anti-ghosting). For all other cnt values, an = ~(4'b0001 << slot).
- Handshake:
  - load=1 with ready=1 captures operand into pending and drops ready to 0 at that edge.
  - load while ready=0 is ignored; the pending word is not overwritten.
- Frame transfer: on the edge where slot==3 and cnt==REFRESH_DIV-1, if pending is full, the display register takes pending and ready returns to 1.
- Simultaneous transfer and load:
  - If ready=1 on the transfer edge, pending is empty and there is nothing to transfer; the load is captured into pending.
  - That word is displayed from the frame after next.
- Segment values:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - minus=0111111, blank=1111111, E=0000110.
- Blanking (BLANK_LEADING=1):
  - digit3 is blank if it is 0.
  - digit2 is blank if digit3 is blank and digit2 is 0.
  - digit1 is never blanked.
- Sign position:
  - minus if sign=1 and the magnitude is nonzero.
  - blank otherwise; -0 displays as "0".
- Error:
  - If any displayed digit is greater than 9, err=1 from the first registered cycle after transfer.
  - In that case the three digit positions show E, the sign position is blank, and blanking rules are bypassed.
  - err clears on the next valid transfer or on reset.

Decomposition:
- Package calc_display_pkg holds:
  - localparams OPERAND_W=13 and DIGIT_W=4.
  - Segment constants SEG_BLANK, SEG_MINUS, SEG_E, and the 10-entry digit table.
  - Slot enum SLOT_D1, SLOT_D2, SLOT_D3, SLOT_SIGN.
- One combinational sub-module, bcd_to_seg: 4-bit digit in, 7-bit active-low segments plus invalid flag out.
- Scan counter, handshake, blanking and output registers live in operand_display_scanner.

Test Plan:
All scenarios use REFRESH_DIV=4, i.e. a 16-clock frame.
- Reset: hold reset=0 for 2 cycles, then release → an=1111, seg=1111111, ready=1, err=0. The first frame shows digit1 "0" (1000000), other positions blank, and one dead cycle per slot.
- Positive value: load operand=13'b0_0001_0010_0011 (+123) → ready=0 until the frame edge. Next frame shows an=1110 seg=0110000, an=1101 seg=0100100, an=1011 seg=1111001, and an=0111 seg=1111111.
- Negative small value with blanking: load {1,0,0,5} → digit1 seg=0010010, digit2 and digit3 blank, sign seg=0111111. With BLANK_LEADING=0, digit2 and digit3 show 1000000.
- Negative zero: load {1,0,0,0} → sign blank, digit1 1000000.
- Invalid BCD: load {0,4'hA,0,1} → after transfer err=1, digit positions 0000110, sign blank. A following load of +7 clears err at the next frame edge.
- Handshake and reset:
  - Load +1 mid-frame, then load +9 while ready=0 → +9 is ignored and +1 is displayed.
  - Load exactly on the transfer edge with ready=1 → shown one frame later.
  - reset=0 mid-slot → all outputs return to reset values on the next edge and pending is dropped.

Source files
------------

// File: rtl/calc_display_pkg.sv
// Shared constants for the operand display path: widths, active-low segment
// patterns {g,f,e,d,c,b,a} and the scan slot encoding.
package calc_display_pkg;

  localparam int OPERAND_W = 13;
  localparam int DIGIT_W   = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Index n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {
    SLOT_D1   = 2'd0,
    SLOT_D2   = 2'd1,
    SLOT_D3   = 2'd2,
    SLOT_SIGN = 2'd3
  } slot_e;

  function automatic logic [3:0] anode_for(input slot_e s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder; digits above 9
// decode to "E" and raise invalid.
module bcd_to_seg
  import calc_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg,
  output logic               invalid
);

  // Table lookup with a catch-all for non-BCD codes.
  always_comb begin
    seg     = SEG_E;
    invalid = 1'b0;
    case (digit)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: begin
        seg     = SEG_E;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/operand_display_scanner.sv
// Multiplexed 4-position seven-segment driver for a sign-magnitude BCD word,
// with a load/ready pending slot that only reaches the display at frame end.
module operand_display_scanner
  import calc_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [OPERAND_W-1:0] operand,
  output logic                 ready,
  output logic                 err,
  output logic [3:0]           an,
  output logic [6:0]           seg
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]     cnt_r;
  slot_e                slot_r;
  logic [OPERAND_W-1:0] disp_r;
  logic [OPERAND_W-1:0] pend_r;
  logic                 ready_r;
  logic                 err_r;
  logic [3:0]           an_r;
  logic [6:0]           seg_r;

  logic       frame_end_s;
  logic [6:0] seg1_s, seg2_s, seg3_s;
  logic       inv1_s, inv2_s, inv3_s;
  logic       invalid_s, mag_zero_s, blank3_s, blank2_s;
  logic [3:0] an_next_s;
  logic [6:0] seg_next_s;

  bcd_to_seg u_d1 (.digit(disp_r[3:0]),  .seg(seg1_s), .invalid(inv1_s));
  bcd_to_seg u_d2 (.digit(disp_r[7:4]),  .seg(seg2_s), .invalid(inv2_s));
  bcd_to_seg u_d3 (.digit(disp_r[11:8]), .seg(seg3_s), .invalid(inv3_s));

  assign frame_end_s = (slot_r == SLOT_SIGN) && (cnt_r == CNT_LAST);
  assign invalid_s   = inv1_s | inv2_s | inv3_s;
  assign mag_zero_s  = (disp_r[11:0] == 12'd0);
  assign blank3_s    = BLANK_LEADING && (disp_r[11:8] == 4'd0);
  assign blank2_s    = blank3_s && (disp_r[7:4] == 4'd0);

  // Select anode and segment pattern for the current slot; cnt==0 is dead time.
  always_comb begin
    an_next_s  = 4'b1111;
    seg_next_s = SEG_BLANK;
    if (cnt_r == '0) begin
      an_next_s  = 4'b1111;
      seg_next_s = SEG_BLANK;
    end else begin
      an_next_s = anode_for(slot_r);
      case (slot_r)
        SLOT_D1:   seg_next_s = invalid_s ? SEG_E : seg1_s;
        SLOT_D2:   seg_next_s = invalid_s ? SEG_E : (blank2_s ? SEG_BLANK : seg2_s);
        SLOT_D3:   seg_next_s = invalid_s ? SEG_E : (blank3_s ? SEG_BLANK : seg3_s);
        SLOT_SIGN: seg_next_s = (!invalid_s && disp_r[12] && !mag_zero_s) ? SEG_MINUS : SEG_BLANK;
        default:   seg_next_s = SEG_BLANK;
      endcase
    end
  end

  // Slot timebase and registered display outputs.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      cnt_r  <= '0;
      slot_r <= SLOT_D1;
      err_r  <= 1'b0;
      an_r   <= 4'b1111;
      seg_r  <= SEG_BLANK;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      err_r <= invalid_s;
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= '0;
        slot_r <= slot_e'(slot_r + 2'd1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Pending slot handshake; the display word only changes at frame end.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      disp_r  <= '0;
      pend_r  <= '0;
      ready_r <= 1'b1;
    end else if (frame_end_s && !ready_r) begin
      disp_r  <= pend_r;
      ready_r <= 1'b1;
    end else if (load && ready_r) begin
      pend_r  <= operand;
      ready_r <= 1'b0;
    end else begin
      ready_r <= ready_r;
    end
  end

  assign ready = ready_r;
  assign err   = err_r;
  assign an    = an_r;
  assign seg   = seg_r;

endmodule

// File: tb/tb_operand_display_scanner.sv
// Directed scoreboard bench for operand_display_scanner with a 16-clock frame,
// running blanking-enabled and blanking-disabled instances side by side.
module tb_operand_display_scanner;

  typedef struct packed {
    logic [3:0][6:0] seg_bl;
    logic [3:0][6:0] seg_nb;
    logic            err;
  } frame_t;

  logic        Clock = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [12:0] operand = 13'd0;
  logic        ready_a, err_a, ready_b, err_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  int errors = 0;
  int checks = 0;
  int e = 0;
  frame_t sb[$];
  frame_t cur;

  localparam logic [3:0][6:0] F_ZERO_BL = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [3:0][6:0] F_ZERO_NB = {7'h7F, 7'h40, 7'h40, 7'h40};

  operand_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .Clock(Clock), .reset(reset), .load(load), .operand(operand),
    .ready(ready_a), .err(err_a), .an(an_a), .seg(seg_a)
  );

  operand_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .Clock(Clock), .reset(reset), .load(load), .operand(operand),
    .ready(ready_b), .err(err_b), .an(an_b), .seg(seg_b)
  );

  always #5 Clock = ~Clock;

  // Edges since reset release; phase e%16 tracks position within a frame.
  always @(posedge Clock) begin
    if (!reset) e <= 0;
    else        e <= e + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      tick();
      n++;
    end while (((e % 16) != p) && (n < 40));
    chk("wait_phase", 32'(e % 16), 32'(p));
  endtask

  task automatic check_frame(input frame_t f, input string tag);
    wait_phase(1);
    for (int k = 0; k < 16; k++) begin
      int         slot;
      int         cnt;
      logic [3:0] exp_an;
      logic [6:0] exp_a, exp_b;
      if (k > 0) tick();
      slot = k / 4;
      cnt  = k % 4;
      if (cnt == 0) begin
        exp_an = 4'b1111;
        exp_a  = 7'h7F;
        exp_b  = 7'h7F;
      end else begin
        exp_an = ~(4'b0001 << slot);
        exp_a  = f.seg_bl[slot];
        exp_b  = f.seg_nb[slot];
      end
      chk($sformatf("%s.an[%0d]", tag, k), 32'(an_a), 32'(exp_an));
      chk($sformatf("%s.an_nb[%0d]", tag, k), 32'(an_b), 32'(exp_an));
      chk($sformatf("%s.seg[%0d]", tag, k), 32'(seg_a), 32'(exp_a));
      chk($sformatf("%s.seg_nb[%0d]", tag, k), 32'(seg_b), 32'(exp_b));
      chk($sformatf("%s.err[%0d]", tag, k), 32'(err_a), 32'(f.err));
      chk($sformatf("%s.err_nb[%0d]", tag, k), 32'(err_b), 32'(f.err));
    end
  endtask

  task automatic push(input logic [3:0][6:0] bl, input logic [3:0][6:0] nb, input logic er);
    frame_t f;
    f = '{seg_bl: bl, seg_nb: nb, err: er};
    sb.push_back(f);
  endtask

  task automatic show_next(input string tag);
    frame_t f;
    chk({tag, ".sb_size"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      f   = sb.pop_front();
      cur = f;
    end else begin
      f = cur;
    end
    check_frame(f, tag);
  endtask

  task automatic do_load(input logic [12:0] op);
    operand = op;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk({tag, ".ready"}, 32'(ready_a), 32'(exp));
    chk({tag, ".ready_nb"}, 32'(ready_b), 32'(exp));
  endtask

  task automatic load_show(input string tag, input int ph, input logic [12:0] op,
                           input logic [3:0][6:0] bl, input logic [3:0][6:0] nb, input logic er);
    wait_phase(ph);
    do_load(op);
    push(bl, nb, er);
    chk_ready({tag, ".after_load"}, 1'b0);
    wait_phase(0);
    chk_ready({tag, ".after_xfer"}, 1'b1);
    show_next(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".an"}, 32'(an_a), 32'h0F);
    chk({tag, ".an_nb"}, 32'(an_b), 32'h0F);
    chk({tag, ".seg"}, 32'(seg_a), 32'h7F);
    chk({tag, ".seg_nb"}, 32'(seg_b), 32'h7F);
    chk({tag, ".err"}, 32'(err_a), 32'd0);
    chk({tag, ".err_nb"}, 32'(err_b), 32'd0);
    chk_ready(tag, 1'b1);
  endtask

  initial begin
    cur = '{seg_bl: F_ZERO_BL, seg_nb: F_ZERO_NB, err: 1'b0};

    reset = 1'b0;
    tick();
    chk_reset_outputs("reset");
    tick();
    reset = 1'b1;
    check_frame(cur, "reset_frame");

    load_show("pos123", 5, 13'b0_0001_0010_0011,
              {7'h7F, 7'h79, 7'h24, 7'h30}, {7'h7F, 7'h79, 7'h24, 7'h30}, 1'b0);
    load_show("neg5", 3, {1'b1, 4'd0, 4'd0, 4'd5},
              {7'h3F, 7'h7F, 7'h7F, 7'h12}, {7'h3F, 7'h40, 7'h40, 7'h12}, 1'b0);
    load_show("negzero", 9, {1'b1, 4'd0, 4'd0, 4'd0}, F_ZERO_BL, F_ZERO_NB, 1'b0);
    load_show("badbcd", 1, {1'b0, 4'hA, 4'd0, 4'd1},
              {7'h7F, 7'h06, 7'h06, 7'h06}, {7'h7F, 7'h06, 7'h06, 7'h06}, 1'b1);
    load_show("pos7", 13, {1'b0, 4'd0, 4'd0, 4'd7},
              {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h40, 7'h40, 7'h78}, 1'b0);

    // A second load while the slot is full must not replace the first.
    wait_phase(2);
    do_load({1'b0, 4'd0, 4'd0, 4'd1});
    push({7'h7F, 7'h7F, 7'h7F, 7'h79}, {7'h7F, 7'h40, 7'h40, 7'h79}, 1'b0);
    wait_phase(6);
    do_load({1'b0, 4'd0, 4'd0, 4'd9});
    chk_ready("ignore.busy", 1'b0);
    wait_phase(0);
    chk_ready("ignore.xfer", 1'b1);
    show_next("ignore");

    // Load sampled on the transfer edge itself lands one frame later.
    wait_phase(15);
    do_load({1'b0, 4'd0, 4'd3, 4'd0});
    chk_ready("edge.captured", 1'b0);
    push({7'h7F, 7'h7F, 7'h30, 7'h40}, {7'h7F, 7'h40, 7'h30, 7'h40}, 1'b0);
    check_frame(cur, "edge_old");
    chk_ready("edge.xfer", 1'b1);
    show_next("edge_new");

    load_show("neg806", 7, {1'b1, 4'd8, 4'd0, 4'd6},
              {7'h3F, 7'h00, 7'h40, 7'h02}, {7'h3F, 7'h00, 7'h40, 7'h02}, 1'b0);
    load_show("badbcd2", 4, {1'b0, 4'd0, 4'hF, 4'd2},
              {7'h7F, 7'h06, 7'h06, 7'h06}, {7'h7F, 7'h06, 7'h06, 7'h06}, 1'b1);

    // Mid-frame reset with err set and a word pending.
    wait_phase(2);
    do_load({1'b0, 4'd0, 4'd0, 4'd9});
    chk_ready("midrst.pending", 1'b0);
    wait_phase(6);
    reset = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    tick();
    reset = 1'b1;
    cur = '{seg_bl: F_ZERO_BL, seg_nb: F_ZERO_NB, err: 1'b0};
    check_frame(cur, "midrst_frame1");
    chk_ready("midrst.frame_end", 1'b1);
    check_frame(cur, "midrst_frame2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
